// File: rtl/stopwatch_cmd_ctrl.sv
// Button front-end for the BCD stopwatch core: sync, debounce, latch presses, and
// issue one-hot command pulses by fixed priority with a holdoff gap; also paces the tick.
`timescale 1ns/1ps
module stopwatch_cmd_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int HOLDOFF    = 2,
    parameter int TICK_DIV   = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_stop,
    input  logic       btn_clr,
    input  logic       btn_load,
    input  logic       tick_en,
    output logic       cmd_start,
    output logic       cmd_lap,
    output logic       cmd_stop,
    output logic       cmd_clr,
    output logic       cmd_load,
    output logic       tick,
    output logic [4:0] pend,
    output logic       busy
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    // Bit order matches pend: index 0 (clr) is the highest priority.
    logic [4:0]         w_btn;
    logic [4:0]         r_sync1, r_sync2, r_deb, w_rise;
    logic [4:0][DW-1:0] r_deb_cnt;
    logic [4:0]         r_pend, r_cmd, w_grant, w_cmd_nxt;
    logic               w_issue;
    state_t             r_state, w_state_nxt;
    logic [HW-1:0]      r_hold_cnt;
    logic [TW-1:0]      r_tick_cnt;
    logic               r_tick;

    assign w_btn = {btn_load, btn_start, btn_lap, btn_stop, btn_clr};

    always_comb begin
        w_rise = '0;
        for (int i = 0; i < 5; i++)
            w_rise[i] = r_sync2[i] & ~r_deb[i] & (r_deb_cnt[i] == DW'(DEB_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_deb     <= '0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Isolate the lowest set bit: that is the highest-priority request.
    assign w_grant = r_pend & (~r_pend + 5'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (r_pend != '0 && HOLDOFF != 0) w_state_nxt = S_HOLD;
            S_HOLD: if (r_hold_cnt <= HW'(1))         w_state_nxt = S_IDLE;
            default:                                   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_issue   = (r_state == S_IDLE) && (r_pend != '0);
        w_cmd_nxt = w_issue ? w_grant : '0;
    end

    // New presses are OR-ed in after the grant clears, so a same-edge set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd      <= '0;
            r_pend     <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_cmd  <= w_cmd_nxt;
            r_pend <= (r_pend & ~w_cmd_nxt) | w_rise;
            if (w_issue)
                r_hold_cnt <= HW'(HOLDOFF);
            else if (r_state == S_HOLD && r_hold_cnt != '0)
                r_hold_cnt <= r_hold_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (w_cmd_nxt[0]) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (tick_en) begin
            if (r_tick_cnt == TW'(TICK_DIV - 1)) begin
                r_tick_cnt <= '0;
                r_tick     <= 1'b1;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
                r_tick     <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign cmd_clr   = r_cmd[0];
    assign cmd_stop  = r_cmd[1];
    assign cmd_lap   = r_cmd[2];
    assign cmd_start = r_cmd[3];
    assign cmd_load  = r_cmd[4];
    assign tick      = r_tick;
    assign pend      = r_pend;
    assign busy      = (r_state != S_IDLE) || (r_pend != '0);
endmodule

// File: tb/tb_stopwatch_cmd_ctrl.sv
// Directed bench for stopwatch_cmd_ctrl: press latency, glitches, priority spacing,
// pending during HOLD, tick pacing/clr restart and asynchronous reset.
`timescale 1ns/1ps
module tb_stopwatch_cmd_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       btn_start = 1'b0, btn_lap = 1'b0, btn_stop = 1'b0, btn_clr = 1'b0, btn_load = 1'b0;
    logic       tick_en = 1'b0;
    logic       cmd_start, cmd_lap, cmd_stop, cmd_clr, cmd_load, tick, busy;
    logic [4:0] pend;
    logic [4:0] cmdv;

    int checks = 0, failures = 0;
    int n_cmd = 0, n_multi = 0;

    stopwatch_cmd_ctrl #(.DEB_CYCLES(4), .HOLDOFF(2), .TICK_DIV(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_start(btn_start), .btn_lap(btn_lap), .btn_stop(btn_stop),
        .btn_clr(btn_clr), .btn_load(btn_load), .tick_en(tick_en),
        .cmd_start(cmd_start), .cmd_lap(cmd_lap), .cmd_stop(cmd_stop),
        .cmd_clr(cmd_clr), .cmd_load(cmd_load),
        .tick(tick), .pend(pend), .busy(busy)
    );

    always #5 clk = ~clk;

    assign cmdv = {cmd_load, cmd_start, cmd_lap, cmd_stop, cmd_clr};

    // Running tally of issued commands and one-hot violations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmdv != 5'd0) n_cmd++;
            if ($countones(cmdv) > 1) n_multi++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        cyc(3);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_cmd", 32'(cmdv), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tick", 32'(tick), 0);
        rst_n = 1'b1;
        cyc(2);

        // Single press: pend at e6, cmd e7..e8, busy low after e10
        btn_start = 1'b1;
        cyc(5);
        chk("sp_pend_e5", 32'(pend), 0);
        cyc(1);
        chk("sp_pend_e6", 32'(pend), 32'b01000);
        chk("sp_cmd_e6", 32'(cmdv), 0);
        cyc(1);
        chk("sp_cmd_e7", 32'(cmdv), 32'b01000);
        chk("sp_pend_e7", 32'(pend), 0);
        chk("sp_busy_e7", 32'(busy), 1);
        cyc(1);
        chk("sp_cmd_e8", 32'(cmdv), 0);
        chk("sp_busy_e8", 32'(busy), 1);
        cyc(3);
        chk("sp_busy_e11", 32'(busy), 0);
        cyc(9);
        btn_start = 1'b0;
        cyc(10);
        chk("sp_pend_end", 32'(pend), 0);
        chk("sp_ncmd", 32'(n_cmd), 1);

        // Glitch of 3 cycles is rejected
        btn_lap = 1'b1;
        cyc(3);
        btn_lap = 1'b0;
        cyc(10);
        chk("gl_pend", 32'(pend), 0);
        chk("gl_ncmd", 32'(n_cmd), 1);

        // Simultaneous load/lap/clr: clr e7, lap e10, load e13
        btn_load = 1'b1; btn_lap = 1'b1; btn_clr = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cyc(1);
            if (k == 6) chk("sim_pend_e6", 32'(pend), 32'b10101);
            if (k >= 7)
                chk($sformatf("sim_cmd_e%0d", k), 32'(cmdv),
                    (k == 7) ? 32'b00001 : (k == 10) ? 32'b00100 : (k == 13) ? 32'b10000 : 32'd0);
        end
        btn_load = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
        cyc(10);
        chk("sim_pend_end", 32'(pend), 0);
        chk("sim_ncmd", 32'(n_cmd), 4);

        // Stop request arrives during clr's HOLD window and waits for it
        btn_clr = 1'b1;
        cyc(2);
        btn_stop = 1'b1;
        for (int k = 3; k <= 12; k++) begin
            cyc(1);
            if (k == 8) begin
                chk("hold_pend_e8", 32'(pend), 32'b00010);
                chk("hold_busy_e8", 32'(busy), 1);
            end
            if (k >= 7)
                chk($sformatf("hold_cmd_e%0d", k), 32'(cmdv),
                    (k == 7) ? 32'b00001 : (k == 10) ? 32'b00010 : 32'd0);
        end
        btn_clr = 1'b0; btn_stop = 1'b0;
        cyc(10);
        chk("hold_ncmd", 32'(n_cmd), 6);

        // Tick: period 5, stretched to 8 by a 3-cycle gap, restart on cmd_clr
        tick_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            chk($sformatf("tick_e%0d", k), 32'(tick), (k % 5 == 0) ? 32'd1 : 32'd0);
        end
        tick_en = 1'b0;
        for (int k = 11; k <= 13; k++) begin
            cyc(1);
            chk($sformatf("tick_e%0d", k), 32'(tick), 0);
        end
        tick_en = 1'b1;
        for (int k = 14; k <= 18; k++) begin
            cyc(1);
            chk($sformatf("tick_e%0d", k), 32'(tick), (k == 18) ? 32'd1 : 32'd0);
        end
        btn_clr = 1'b1;
        for (int k = 19; k <= 31; k++) begin
            cyc(1);
            chk($sformatf("tick_e%0d", k), 32'(tick), (k == 23 || k == 30) ? 32'd1 : 32'd0);
            if (k == 25) chk("tick_clr_e25", 32'(cmd_clr), 1);
        end
        btn_clr = 1'b0;
        cyc(10);
        chk("tick_ncmd", 32'(n_cmd), 7);

        // Asynchronous reset in HOLD with pend = 00110
        btn_clr = 1'b1; btn_stop = 1'b1; btn_lap = 1'b1;
        cyc(6);
        chk("rs_pend_e6", 32'(pend), 32'b00111);
        cyc(1);
        chk("rs_pend_e7", 32'(pend), 32'b00110);
        chk("rs_cmd_e7", 32'(cmdv), 32'b00001);
        chk("rs_busy_e7", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_async_cmd", 32'(cmdv), 0);
        chk("rs_async_pend", 32'(pend), 0);
        chk("rs_async_busy", 32'(busy), 0);
        chk("rs_async_tick", 32'(tick), 0);
        btn_clr = 1'b0; btn_stop = 1'b0; btn_lap = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(15);
        chk("rs_post_pend", 32'(pend), 0);
        chk("rs_post_ncmd", 32'(n_cmd), 7);
        chk("onehot", 32'(n_multi), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stopwatch_cmd_ctrl.md
# stopwatch_cmd_ctrl

Front-end controller that sequences the BCD stopwatch core. It synchronizes and debounces five raw push-buttons and latches each press as a pending request. A fixed-priority arbiter then issues the requests to the core as one-hot, single-cycle command pulses, spaced by a programmable holdoff. It also generates the gated count-enable tick that paces the core's minute counter.

## Interface
- DEB_CYCLES, 4, consecutive stable synchronized samples needed to change a debounced level; legal values ≥ 1
- HOLDOFF, 2, idle cycles inserted after each issued command; legal values ≥ 0
- TICK_DIV, 60, clk cycles per tick pulse; legal values ≥ 2
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- btn_start, btn_lap, btn_stop, btn_clr, btn_load  in  1 each  raw buttons, active-high, asynchronous to clk
- tick_en  in  1  level enable for the tick prescaler
- cmd_start, cmd_lap, cmd_stop, cmd_clr, cmd_load  out  1 each  registered command pulses; at most one is high in any cycle
- tick  out  1  registered one-cycle pulse every TICK_DIV enabled cycles
- pend  out  5  pending requests, bit order {load, start, lap, stop, clr} = [4:0]
- busy  out  1  high when the arbiter is not in IDLE or pend ≠ 0

## Operation
- **Reset:** asynchronous. All sync flops, debounced levels, debounce counters, pend, the FSM (to IDLE), the hold counter, the tick counter and every output go to 0 immediately. A reset asserted mid-operation drops pulses immediately and discards all pending requests.
- **Synchronizer:** each button passes through a 2-flop synchronizer.
- **Debounce (per button):**
  - A counter increments on every edge where the synchronized value differs from the debounced level.
  - The counter clears on any edge where the two are equal.
  - When the synchronized value has differed on DEB_CYCLES consecutive edges, the debounced level flips and the counter clears.
- **Request latch:**
  - A debounced 0→1 transition sets the corresponding pend bit on the same edge the level flips.
  - Releases are ignored.
  - A repeat press while the bit is already set merges into that single request.
  - If set and clear hit the same bit on the same edge, set wins.
- **Arbiter FSM (states IDLE, HOLD):**
  - IDLE with pend ≠ 0: on the next edge, the highest-priority pending bit is selected. Priority is clr > stop > lap > start > load.
  - On that edge the matching cmd_* goes high for one cycle, that pend bit clears, and the hold counter loads HOLDOFF.
  - The FSM then enters HOLD. If HOLDOFF = 0 it stays in IDLE instead.
  - HOLD: the hold counter decrements each edge. The FSM returns to IDLE once it has spent HOLDOFF cycles in HOLD.
  - Requests arriving during HOLD remain pending.
- **Tick prescaler:**
  - Counter width is clog2(TICK_DIV). It counts 0..TICK_DIV-1 while tick_en = 1 and holds while tick_en = 0.
  - On the edge that wraps the counter from TICK_DIV-1 to 0, tick is registered high for one cycle.
  - The edge on which cmd_clr is registered high forces the counter to 0 and suppresses tick on that edge. The clr override takes priority over wrap.

## Timing
- **Press latency:** let e1 be the first edge sampling a raw button high that then stays stable.
  - sync2 goes high at e2.
  - Debounce samples run e3..e(2+DEB_CYCLES).
  - The debounced level and pend bit set at e(2+DEB_CYCLES).
  - cmd rises at e(3+DEB_CYCLES) and falls one edge later.
  - With DEB_CYCLES = 4, cmd is high between e7 and e8.
- **Command spacing:** successive command rising edges are exactly 1+HOLDOFF cycles apart while requests are pending.
- **Glitches:** a raw glitch shorter than DEB_CYCLES synchronized cycles produces no pend bit and no command.
- **Tick period:** with tick_en held high, tick pulses every TICK_DIV cycles. The first pulse occurs TICK_DIV edges after tick_en is first sampled high following reset.
- **busy:** a registered-state function (no combinational path from the buttons). It falls in the cycle after the last HOLD cycle once pend = 0.

## Test plan
- **Reset values:** assert rst_n = 0 mid-count with pend = 5'b00110 and FSM in HOLD → all outputs are 0 the same cycle. After release, no command issues without a new press.
- **Single press:** DEB_CYCLES = 4. btn_start held high from e1 for 20 cycles → pend[3] sets at e6; cmd_start is high e7..e8 only; pend returns to 0; busy falls after e10.
- **Glitch rejection:** btn_lap pulsed high for 3 clk cycles → no change in pend or cmd_*.
- **Simultaneous requests:** btn_load, btn_lap and btn_clr rise on the same cycle, HOLDOFF = 2 → commands issue cmd_clr at eN, cmd_lap at eN+3, cmd_load at eN+6, each exactly one cycle wide and never overlapping.
- **Merge and hold:** btn_stop pressed twice during another command's HOLD window → exactly one cmd_stop is issued, after the HOLD window ends.
- **Tick:** TICK_DIV = 5, tick_en = 1 → tick every 5 cycles. tick_en dropped for 3 cycles → the period stretches to 8. A cmd_clr issued mid-count → the counter restarts and the next tick comes 5 cycles after cmd_clr.
